riscv_mem_arbiter: RTL

//  Shares one unified line-wide memory port between the I-cache refill FSM and the D-cache refill/write-back FSM.

---
 rtl/riscv_mem_arbiter.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/riscv_mem_arbiter.sv
// Round-robin arbiter sharing one line-wide memory port between the I-cache
// refill path and the D-cache refill/write-back path. One transaction is in
// flight at a time, and completion is returned only to the side that owns it.
module riscv_mem_arbiter #(
  parameter int unsigned DATA_WIDTH  = 128,
  parameter int unsigned S_ADDR      = 10,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic                  i_riscv_arb_clk,
  input  logic                  i_riscv_arb_rst,
  input  logic                  i_riscv_arb_imem_rden,
  input  logic [S_ADDR-1:0]     i_riscv_arb_imem_addr,
  output logic [DATA_WIDTH-1:0] o_riscv_arb_imem_data,
  output logic                  o_riscv_arb_imem_ready,
  input  logic                  i_riscv_arb_dmem_rden,
  input  logic                  i_riscv_arb_dmem_wren,
  input  logic [S_ADDR-1:0]     i_riscv_arb_dmem_addr,
  input  logic [DATA_WIDTH-1:0] i_riscv_arb_dmem_wdata,
  output logic [DATA_WIDTH-1:0] o_riscv_arb_dmem_data,
  output logic                  o_riscv_arb_dmem_ready,
  output logic                  o_riscv_arb_mem_rden,
  output logic                  o_riscv_arb_mem_wren,
  output logic [S_ADDR-1:0]     o_riscv_arb_mem_addr,
  output logic [DATA_WIDTH-1:0] o_riscv_arb_mem_wdata,
  input  logic [DATA_WIDTH-1:0] i_riscv_arb_mem_data,
  input  logic                  i_riscv_arb_mem_ready,
  output logic                  o_riscv_arb_timeout
);

  localparam int unsigned WdogW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [WdogW-1:0] WdogMax = WdogW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {StIdle, StGntI, StGntD} state_e;

  state_e           state_q, state_d;
  logic             last_q, last_d;      // 0: I served last, 1: D served last
  logic             mask_i_q, mask_i_d;
  logic             mask_d_q, mask_d_d;
  logic [WdogW-1:0] wdog_q, wdog_d;
  logic             timeout_q, timeout_d;

  logic req_i, req_d;

  // The mask hides the requester's stale level during the IDLE cycle after its completion
  assign req_i = i_riscv_arb_imem_rden & ~mask_i_q;
  assign req_d = (i_riscv_arb_dmem_rden | i_riscv_arb_dmem_wren) & ~mask_d_q;

  // State and bookkeeping registers
  always_ff @(posedge i_riscv_arb_clk or negedge i_riscv_arb_rst) begin
    if (!i_riscv_arb_rst) begin
      state_q   <= StIdle;
      last_q    <= 1'b0;
      mask_i_q  <= 1'b0;
      mask_d_q  <= 1'b0;
      wdog_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      mask_i_q  <= mask_i_d;
      mask_d_q  <= mask_d_d;
      wdog_q    <= wdog_d;
      timeout_q <= timeout_d;
    end
  end

  // Next-state: grant decision, completion bookkeeping, watchdog
  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    mask_i_d  = 1'b0;
    mask_d_d  = 1'b0;
    wdog_d    = wdog_q;
    timeout_d = timeout_q;
    unique case (state_q)
      StIdle: begin
        wdog_d = '0;
        if (req_i && req_d) begin
          state_d = last_q ? StGntI : StGntD;
        end else if (req_i) begin
          state_d = StGntI;
        end else if (req_d) begin
          state_d = StGntD;
        end
      end
      StGntI, StGntD: begin
        if (wdog_q != WdogMax) begin
          wdog_d = wdog_q + WdogW'(1);
        end
        // The transaction keeps waiting; only the sticky flag reports it
        if (!i_riscv_arb_mem_ready && (wdog_q == WdogMax)) begin
          timeout_d = 1'b1;
        end
        if (i_riscv_arb_mem_ready) begin
          state_d = StIdle;
          if (state_q == StGntI) begin
            last_d   = 1'b0;
            mask_i_d = 1'b1;
          end else begin
            last_d   = 1'b1;
            mask_d_d = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs: memory port muxed from the owner, completion routed back to the owner only
  always_comb begin
    o_riscv_arb_mem_rden   = 1'b0;
    o_riscv_arb_mem_wren   = 1'b0;
    o_riscv_arb_mem_addr   = '0;
    o_riscv_arb_mem_wdata  = '0;
    o_riscv_arb_imem_ready = 1'b0;
    o_riscv_arb_imem_data  = '0;
    o_riscv_arb_dmem_ready = 1'b0;
    o_riscv_arb_dmem_data  = '0;
    unique case (state_q)
      StGntI: begin
        o_riscv_arb_mem_rden   = i_riscv_arb_imem_rden;
        o_riscv_arb_mem_addr   = i_riscv_arb_imem_addr;
        o_riscv_arb_imem_ready = i_riscv_arb_mem_ready;
        if (i_riscv_arb_mem_ready) begin
          o_riscv_arb_imem_data = i_riscv_arb_mem_data;
        end
      end
      StGntD: begin
        // A write-back wins over a read asserted in the same cycle
        o_riscv_arb_mem_wren   = i_riscv_arb_dmem_wren;
        o_riscv_arb_mem_rden   = i_riscv_arb_dmem_rden & ~i_riscv_arb_dmem_wren;
        o_riscv_arb_mem_addr   = i_riscv_arb_dmem_addr;
        o_riscv_arb_mem_wdata  = i_riscv_arb_dmem_wdata;
        o_riscv_arb_dmem_ready = i_riscv_arb_mem_ready;
        if (i_riscv_arb_mem_ready) begin
          o_riscv_arb_dmem_data = i_riscv_arb_mem_data;
        end
      end
      default: ;
    endcase
  end

  assign o_riscv_arb_timeout = timeout_q;

endmodule
